// File: rtl/m68kmem_pkg.sv
// m68kmem_pkg: shared definitions for the 68k-to-async-SRAM bridge.
//   DATA_W  : SRAM / 68k data bus width
//   CNT_W   : width of the ACCESS wait-state counter
//   state_t : bridge FSM states
package m68kmem_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    ACK    = 3'd4
  } state_t;

endpackage

// File: rtl/m68kmem_reqbuf.sv
// m68kmem_reqbuf: one-entry holding register for a request that arrives
// while the bridge is busy.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : store i_data (caller only pushes when empty or popping)
//   i_pop     : release the stored entry
//   i_data    : packed request {wr, wdata, addr}
//   o_data    : stored request
//   o_valid   : entry present
//   o_full    : no room for another request
module m68kmem_reqbuf #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);

  logic [W-1:0] r_data;
  logic         r_valid;

  // A push in the same cycle as a pop replaces the entry being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_full  = r_valid;

endmodule

// File: rtl/m68kmem.sv
// m68kmem: bridges single-cycle 68k bus requests onto an asynchronous
// 16-bit SRAM with SETUP / ACCESS / (HOLD) / ACK sequencing.
//   Parameters : WAIT (extra ACCESS cycles, 0..15), AW (word-address width)
//   clk, rst   : clock, asynchronous active-high reset
//   m68kreq/addr/wdata/wr : request strobe and its qualifiers
//   m68kack, m68krdata    : completion pulse and read data
//   sramaddr, sramd, sramce, sramoe, sramwe : SRAM pins (strobes active low)
// Build option: define M68KMEM_WRPROT_EN to block writes to the ROM region
// (address bit AW-1 low); such writes keep full timing and still ack.
module m68kmem
  import m68kmem_pkg::*;
#(
  parameter int WAIT = 2,
  parameter int AW   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m68kreq,
  input  logic [AW-1:0]     m68kaddr,
  input  logic [DATA_W-1:0] m68kwdata,
  input  logic              m68kwr,
  output logic              m68kack,
  output logic [DATA_W-1:0] m68krdata,
  output logic [AW-1:0]     sramaddr,
  inout  wire  [DATA_W-1:0] sramd,
  output logic              sramce,
  output logic              sramoe,
  output logic              sramwe
);

  localparam int REQ_W = AW + DATA_W + 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [AW-1:0]      r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_wr;
  logic               r_ovf;

  logic [REQ_W-1:0]   w_reqData;
  logic [REQ_W-1:0]   w_bufData;
  logic               w_bufValid;
  logic               w_bufFull;
  logic               w_busy;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_active;
  logic               w_wrEn;
  logic               w_drive;

  assign w_reqData = {m68kwr, m68kwdata, m68kaddr};

  // A queued request always takes priority over a fresh one in IDLE, so a
  // new strobe in that cycle must go behind it in the buffer.
  assign w_pop  = (r_state == IDLE) && w_bufValid;
  assign w_busy = (r_state != IDLE) || w_bufValid;
  assign w_push = m68kreq && w_busy && (!w_bufFull || w_pop);
  assign w_drop = m68kreq && w_busy && w_bufFull && !w_pop;

  m68kmem_reqbuf #(.W(REQ_W)) u_reqbuf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_reqData),
    .o_data  (w_bufData),
    .o_valid (w_bufValid),
    .o_full  (w_bufFull)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wr    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_drop;
      case (r_state)
        IDLE: begin
          if (w_bufValid) begin
            {r_wr, r_wdata, r_addr} <= w_bufData;
            r_state                 <= SETUP;
          end else if (m68kreq) begin
            {r_wr, r_wdata, r_addr} <= w_reqData;
            r_state                 <= SETUP;
          end
        end
        SETUP: begin
          r_cnt   <= CNT_W'(WAIT);
          r_state <= ACCESS;
        end
        ACCESS: begin
          // Counter runs WAIT..0, giving WAIT+1 strobe cycles.
          if (r_cnt == '0) begin
            if (r_wr) begin
              r_state <= HOLD;
            end else begin
              r_rdata <= sramd;
              r_state <= ACK;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD:    r_state <= ACK;
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef M68KMEM_WRPROT_EN
  assign w_wrEn = r_wr && r_addr[AW-1];
`else
  assign w_wrEn = r_wr;
`endif

  assign w_active = (r_state == SETUP) || (r_state == ACCESS) || (r_state == HOLD);
  assign w_drive  = w_active && w_wrEn;

  assign sramaddr  = r_addr;
  assign sramce    = !w_active;
  assign sramoe    = !((r_state == ACCESS) && !r_wr);
  assign sramwe    = !((r_state == ACCESS) && w_wrEn);
  assign sramd     = w_drive ? r_wdata : {DATA_W{1'bz}};
  assign m68kack   = (r_state == ACK);
  assign m68krdata = r_rdata;

endmodule
